slot_scheduler: RTL and testbench

SLOT_SCHEDULER -- requirements
Module: slot_scheduler

---
 rtl/slot_scheduler_if.sv | 31 +++
 rtl/slot_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_slot_scheduler.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_scheduler_if.sv
// slot_scheduler_if
//   Groups the slot strobe bus of slot_scheduler with its requester side.
//   master : the scheduler (drives strobes/grants, samples req)
//   slave  : a client (drives req, observes strobes/grants)
//   Signals:
//     req[3:0]      per-requester slot request, held until granted
//     word_stb      one-cycle pulse per active slot
//     frame_start   pulse with the slot-0 word_stb
//     slot_idx[5:0] current slot number 0..39
//     marker        high with word_stb in slot 0 (sync word)
//     grant[3:0]    one-hot grant, only in word_stb cycles
//     idle_slot     pulse in slots 1..39 when nobody is granted
interface slot_scheduler_if;
  logic [3:0] req;
  logic       word_stb;
  logic       frame_start;
  logic [5:0] slot_idx;
  logic       marker;
  logic [3:0] grant;
  logic       idle_slot;

  modport master (
    input  req,
    output word_stb, frame_start, slot_idx, marker, grant, idle_slot
  );

  modport slave (
    output req,
    input  word_stb, frame_start, slot_idx, marker, grant, idle_slot
  );
endinterface

// File: rtl/slot_scheduler.sv
// slot_scheduler
//   Frame/slot sequencer for a 40-slot TDM frame. Word strobes are derived
//   from the rising edges of the 320 kHz word-clock level, frames are aligned
//   to the rising edges of the 8 kHz frame-clock level. Slot 0 carries the
//   sync word; slots 1..39 are handed out round-robin to four requesters.
//   Ports:
//     clk80     80.64 MHz system clock, rising edge
//     reset     asynchronous, active-low reset
//     enable    run request (level); low forces IDLE
//     clk320k   word-clock level (clk80 domain)
//     clk8k     frame-clock level (clk80 domain)
//     clr_err   synchronous clear of sync_err (a new error wins)
//     bus       strobe/grant bus (master side)
//     frame_cnt completed-frame counter, wraps 255->0
//     sync_err  sticky frame-alignment error
module slot_scheduler (
  input  logic                     clk80,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clk320k,
  input  logic                     clk8k,
  input  logic                     clr_err,
  slot_scheduler_if.master         bus,
  output logic [7:0]               frame_cnt,
  output logic                     sync_err
);

  localparam logic [5:0] LAST_SLOT = 6'd39;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       prev320_q, prev8k_q;
  logic       frame_pend_q, frame_pend_d;
  logic [5:0] slot_idx_q, slot_idx_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       sync_err_q, sync_err_d;
  logic       word_stb_q, word_stb_d;
  logic       frame_start_q, frame_start_d;
  logic       marker_q, marker_d;
  logic [3:0] grant_q, grant_d;
  logic       idle_slot_q, idle_slot_d;

  logic       rise320, rise8k, pend_now, err_set;
  logic       arb_found;
  logic [1:0] arb_idx;

  // Edge detect against the previous cycle's level.
  assign rise320  = clk320k & ~prev320_q;
  assign rise8k   = clk8k & ~prev8k_q;
  // A frame edge arriving in the same cycle as a word edge counts as pending.
  assign pend_now = frame_pend_q | rise8k;

  // Round-robin search starting at rr_ptr; the 2-bit add wraps modulo 4.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!arb_found && bus.req[rr_ptr_q + 2'(i)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_pend_d  = frame_pend_q;
    slot_idx_d    = slot_idx_q;
    rr_ptr_d      = rr_ptr_q;
    frame_cnt_d   = frame_cnt_q;
    err_set       = 1'b0;
    word_stb_d    = 1'b0;
    frame_start_d = 1'b0;
    marker_d      = 1'b0;
    grant_d       = 4'b0000;
    idle_slot_d   = 1'b0;

    if (!enable) begin
      // Any strobe due this cycle is dropped along with the pending frame.
      state_d      = IDLE;
      frame_pend_d = 1'b0;
      slot_idx_d   = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = WAIT_SYNC;
          slot_idx_d   = 6'd0;
          frame_pend_d = 1'b0;
        end
        WAIT_SYNC, RUN: begin
          frame_pend_d = pend_now;
          if (rise320) begin
            if (pend_now) begin
              // Frame boundary: this strobe is slot 0.
              frame_pend_d  = 1'b0;
              state_d       = RUN;
              slot_idx_d    = 6'd0;
              word_stb_d    = 1'b1;
              frame_start_d = 1'b1;
              marker_d      = 1'b1;
              if (state_q == RUN) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                // Frame edge arrived early: resync to slot 0 and flag it.
                if (slot_idx_q < LAST_SLOT) begin
                  err_set = 1'b1;
                end
              end
            end else if (state_q == RUN) begin
              if (slot_idx_q == LAST_SLOT) begin
                // Frame edge missing: stop strobing, park on slot 39.
                err_set = 1'b1;
                state_d = WAIT_SYNC;
              end else begin
                slot_idx_d = slot_idx_q + 6'd1;
                word_stb_d = 1'b1;
                if (arb_found) begin
                  grant_d  = 4'b0001 << arb_idx;
                  rr_ptr_d = arb_idx + 2'd1;
                end else begin
                  idle_slot_d = 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (err_set) begin
      sync_err_d = 1'b1;
    end else if (clr_err) begin
      sync_err_d = 1'b0;
    end else begin
      sync_err_d = sync_err_q;
    end
  end

  always_ff @(posedge clk80 or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      prev320_q     <= 1'b0;
      prev8k_q      <= 1'b0;
      frame_pend_q  <= 1'b0;
      slot_idx_q    <= 6'd0;
      rr_ptr_q      <= 2'd0;
      frame_cnt_q   <= 8'd0;
      sync_err_q    <= 1'b0;
      word_stb_q    <= 1'b0;
      frame_start_q <= 1'b0;
      marker_q      <= 1'b0;
      grant_q       <= 4'b0000;
      idle_slot_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev320_q     <= clk320k;
      prev8k_q      <= clk8k;
      frame_pend_q  <= frame_pend_d;
      slot_idx_q    <= slot_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      frame_cnt_q   <= frame_cnt_d;
      sync_err_q    <= sync_err_d;
      word_stb_q    <= word_stb_d;
      frame_start_q <= frame_start_d;
      marker_q      <= marker_d;
      grant_q       <= grant_d;
      idle_slot_q   <= idle_slot_d;
    end
  end

  assign bus.word_stb    = word_stb_q;
  assign bus.frame_start = frame_start_q;
  assign bus.slot_idx    = slot_idx_q;
  assign bus.marker      = marker_q;
  assign bus.grant       = grant_q;
  assign bus.idle_slot   = idle_slot_q;
  assign frame_cnt       = frame_cnt_q;
  assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// tb_slot_scheduler
//   Directed bench for slot_scheduler: real-rate divider frame, round-robin
//   grants, resync, missing frame edge, enable drop and async reset.
module tb_slot_scheduler;

  localparam int P320 = 252;        // clk80 cycles per 320 kHz period

  logic       clk80 = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic       man320 = 1'b0;
  logic       man8k = 1'b0;
  logic       use_div = 1'b0;
  int         d_cnt = 0;
  int         d_slot = 0;
  int         d_slot_init = 30;
  logic       div320, div8k, clk320k, clk8k;
  logic [7:0] frame_cnt;
  logic       sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Values captured at the strobe sample point of pulse320.
  logic       s_stb, s_fs, s_mk, s_idle, s_err;
  logic [3:0] s_gnt;
  logic [5:0] s_idx;
  logic [7:0] s_fc;

  slot_scheduler_if bus ();

  slot_scheduler dut (
    .clk80     (clk80),
    .reset     (reset),
    .enable    (enable),
    .clk320k   (clk320k),
    .clk8k     (clk8k),
    .clr_err   (clr_err),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .sync_err  (sync_err)
  );

  always #5 clk80 = ~clk80;

  // Real-rate divider: 8 kHz edge lands mid slot 39, so the following
  // 320 kHz edge becomes slot 0 through the pending-frame path.
  always @(posedge clk80) begin
    if (!use_div) begin
      d_cnt  <= 0;
      d_slot <= d_slot_init;
    end else if (d_cnt == P320 - 1) begin
      d_cnt  <= 0;
      d_slot <= (d_slot == 39) ? 0 : d_slot + 1;
    end else begin
      d_cnt <= d_cnt + 1;
    end
  end

  assign div320  = use_div && (d_cnt < P320 / 2);
  assign div8k   = use_div && ((d_slot == 39 && d_cnt >= P320 / 2) || (d_slot < 19));
  assign clk320k = use_div ? div320 : man320;
  assign clk8k   = use_div ? div8k : man8k;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic pulse8k();
    man8k = 1'b1;
    @(negedge clk80);
    man8k = 1'b0;
    @(negedge clk80);
  endtask

  task automatic pulse320(input logic with8k);
    man320 = 1'b1;
    man8k  = with8k;
    @(negedge clk80);
    s_stb  = bus.word_stb;
    s_fs   = bus.frame_start;
    s_mk   = bus.marker;
    s_idle = bus.idle_slot;
    s_gnt  = bus.grant;
    s_idx  = bus.slot_idx;
    s_err  = sync_err;
    s_fc   = frame_cnt;
    $display("strobe: stb=%0b fs=%0b mk=%0b slot=%0d grant=%b idle=%0b err=%0b fcnt=%0d",
             s_stb, s_fs, s_mk, s_idx, s_gnt, s_idle, s_err, s_fc);
    man320 = 1'b0;
    man8k  = 1'b0;
    @(negedge clk80);
  endtask

  task automatic do_reset();
    @(negedge clk80);
    reset = 1'b0; enable = 1'b0; clr_err = 1'b0;
    man320 = 1'b0; man8k = 1'b0; bus.req = 4'b0000;
    repeat (2) @(negedge clk80);
    reset = 1'b1;
    @(negedge clk80);
  endtask

  task automatic start_frame();
    enable = 1'b1;
    @(negedge clk80);
    pulse8k();
    pulse320(1'b0);
  endtask

  task automatic test_reset();
    bus.req = 4'b0000;
    repeat (2) @(negedge clk80);
    n_cmp++;
    if ({bus.word_stb, bus.frame_start, bus.marker, bus.idle_slot, bus.grant} !== 8'h00) begin
      n_bad++; $display("FAIL reset_pulses: got %b expected 00000000",
                        {bus.word_stb, bus.frame_start, bus.marker, bus.idle_slot, bus.grant});
    end
    n_cmp++;
    if (bus.slot_idx !== 6'd0) begin
      n_bad++; $display("FAIL reset_slot_idx: got %0d expected 0", bus.slot_idx);
    end
    n_cmp++;
    if ({frame_cnt, sync_err} !== 9'd0) begin
      n_bad++; $display("FAIL reset_cnt_err: got fcnt=%0d err=%0b expected 0/0", frame_cnt, sync_err);
    end
    reset = 1'b1;
    @(negedge clk80);
    $display("reset released");
  endtask

  task automatic test_real_div();
    int first_fs = -1;
    int n_stb = 0, n_idle = 0, n_mk = 0, n_gnt = 0, n_err = 0, n_off = 0;
    logic [5:0] idx39 = 6'd0;
    logic [5:0] idx_end = 6'd0;
    logic [7:0] fc_start = 8'd0;
    logic [7:0] fc_end = 8'd0;
    logic       fs_end = 1'b0;
    enable  = 1'b1;
    bus.req = 4'b0000;
    d_slot_init = 30;
    @(negedge clk80);
    use_div = 1'b1;
    for (int k = 1; k <= 2521 + 40 * P320; k++) begin
      @(negedge clk80);
      if (bus.frame_start && first_fs < 0) first_fs = k;
      if (sync_err) n_err++;
      if (k >= 2521 && k < 2521 + 40 * P320) begin
        if (bus.word_stb) begin
          n_stb++;
          if ((k - 2521) % P320 != 0) n_off++;
        end
        if (bus.idle_slot) n_idle++;
        if (bus.marker) n_mk++;
        if (bus.grant != 4'b0000) n_gnt++;
      end
      if (k == 2521) fc_start = frame_cnt;
      if (k == 2521 + 39 * P320) idx39 = bus.slot_idx;
      if (k == 2521 + 40 * P320) begin
        fs_end  = bus.frame_start;
        fc_end  = frame_cnt;
        idx_end = bus.slot_idx;
      end
    end
    use_div = 1'b0;
    $display("real divider frame: first_fs=%0d stb=%0d idle=%0d marker=%0d fcnt=%0d",
             first_fs, n_stb, n_idle, n_mk, fc_end);
    n_cmp++;
    if (first_fs != 2521) begin n_bad++; $display("FAIL div_first_fs: got cycle %0d expected 2521", first_fs); end
    n_cmp++;
    if (n_stb != 40) begin n_bad++; $display("FAIL div_stb_count: got %0d expected 40", n_stb); end
    n_cmp++;
    if (n_off != 0) begin n_bad++; $display("FAIL div_stb_spacing: got %0d off-grid expected 0", n_off); end
    n_cmp++;
    if (n_idle != 39) begin n_bad++; $display("FAIL div_idle_count: got %0d expected 39", n_idle); end
    n_cmp++;
    if (n_mk != 1) begin n_bad++; $display("FAIL div_marker_count: got %0d expected 1", n_mk); end
    n_cmp++;
    if (n_gnt != 0) begin n_bad++; $display("FAIL div_grant_count: got %0d expected 0", n_gnt); end
    n_cmp++;
    if (n_err != 0) begin n_bad++; $display("FAIL div_sync_err: got %0d cycles set expected 0", n_err); end
    n_cmp++;
    if (idx39 !== 6'd39) begin n_bad++; $display("FAIL div_last_slot: got %0d expected 39", idx39); end
    n_cmp++;
    if ({fs_end, idx_end} !== {1'b1, 6'd0}) begin
      n_bad++; $display("FAIL div_second_frame: got fs=%0b slot=%0d expected 1/0", fs_end, idx_end);
    end
    n_cmp++;
    if (fc_start !== 8'd0 || fc_end !== 8'd1) begin
      n_bad++; $display("FAIL div_frame_cnt: got %0d then %0d expected 0 then 1", fc_start, fc_end);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    do_reset();
    bus.req = 4'b1111;
    start_frame();
    n_cmp++;
    if ({s_stb, s_fs, s_mk, s_idx, s_gnt} !== {3'b111, 6'd0, 4'b0000}) begin
      n_bad++; $display("FAIL rr_slot0: got stb=%0b fs=%0b mk=%0b slot=%0d grant=%b expected 1/1/1/0/0000",
                        s_stb, s_fs, s_mk, s_idx, s_gnt);
    end
    n_cmp++;
    if (s_fc !== 8'd0) begin n_bad++; $display("FAIL rr_first_fcnt: got %0d expected 0", s_fc); end
    for (int s = 1; s <= 8; s++) begin
      pulse320(1'b0);
      exp_gnt = 4'b0001 << ((s - 1) % 4);
      n_cmp++;
      if ({s_stb, s_idx, s_gnt, s_idle} !== {1'b1, 6'(s), exp_gnt, 1'b0}) begin
        n_bad++; $display("FAIL rr_slot%0d: got stb=%0b slot=%0d grant=%b idle=%0b expected 1/%0d/%b/0",
                          s, s_stb, s_idx, s_gnt, s_idle, s, exp_gnt);
      end
    end
    n_cmp++;
    if ({bus.word_stb, bus.grant} !== 5'b0) begin
      n_bad++; $display("FAIL rr_grant_outside_stb: got stb=%0b grant=%b expected 0/0000", bus.word_stb, bus.grant);
    end
  endtask

  task automatic test_single_req();
    bus.req = 4'b0100;
    pulse320(1'b0);
    n_cmp++;
    if (s_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_first: got %b expected 0100", s_gnt); end
    pulse320(1'b0);
    n_cmp++;
    if (s_gnt !== 4'b0100) begin n_bad++; $display("FAIL single_from_ptr3: got %b expected 0100", s_gnt); end
    bus.req = 4'b1111;
    pulse320(1'b0);
    n_cmp++;
    if (s_gnt !== 4'b1000) begin n_bad++; $display("FAIL single_ptr_is3: got %b expected 1000", s_gnt); end
    bus.req = 4'b0000;
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_gnt, s_idle} !== 6'b1_0000_1) begin
      n_bad++; $display("FAIL single_idle: got stb=%0b grant=%b idle=%0b expected 1/0000/1", s_stb, s_gnt, s_idle);
    end
    bus.req = 4'b1111;
    pulse320(1'b0);
    n_cmp++;
    if ({s_idx, s_gnt} !== {6'd13, 4'b0001}) begin
      n_bad++; $display("FAIL single_ptr_held: got slot=%0d grant=%b expected 13/0001", s_idx, s_gnt);
    end
  endtask

  task automatic test_resync();
    bus.req = 4'b0000;
    for (int s = 14; s <= 17; s++) pulse320(1'b0);
    n_cmp++;
    if (s_idx !== 6'd17) begin n_bad++; $display("FAIL resync_at17: got %0d expected 17", s_idx); end
    pulse8k();
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_fs, s_idx, s_err} !== {2'b11, 6'd0, 1'b1}) begin
      n_bad++; $display("FAIL resync_slot0: got stb=%0b fs=%0b slot=%0d err=%0b expected 1/1/0/1",
                        s_stb, s_fs, s_idx, s_err);
    end
    n_cmp++;
    if (s_fc !== 8'd1) begin n_bad++; $display("FAIL resync_fcnt: got %0d expected 1", s_fc); end
    clr_err = 1'b1;
    @(negedge clk80);
    clr_err = 1'b0;
    n_cmp++;
    if (sync_err !== 1'b0) begin n_bad++; $display("FAIL resync_clr: got %0b expected 0", sync_err); end
  endtask

  task automatic test_missing_frame();
    bus.req = 4'b1111;
    for (int s = 1; s <= 39; s++) pulse320(1'b0);
    n_cmp++;
    if (s_idx !== 6'd39) begin n_bad++; $display("FAIL missing_at39: got %0d expected 39", s_idx); end
    clr_err = 1'b1;
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_gnt, s_idle, s_idx} !== {1'b0, 4'b0000, 1'b0, 6'd39}) begin
      n_bad++; $display("FAIL missing_no_stb: got stb=%0b grant=%b idle=%0b slot=%0d expected 0/0000/0/39",
                        s_stb, s_gnt, s_idle, s_idx);
    end
    n_cmp++;
    if (s_err !== 1'b1) begin n_bad++; $display("FAIL missing_set_wins: got %0b expected 1", s_err); end
    n_cmp++;
    if (sync_err !== 1'b0) begin n_bad++; $display("FAIL missing_clr: got %0b expected 0", sync_err); end
    clr_err = 1'b0;
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_idx} !== {1'b0, 6'd39}) begin
      n_bad++; $display("FAIL missing_wait_sync: got stb=%0b slot=%0d expected 0/39", s_stb, s_idx);
    end
    pulse8k();
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_fs, s_idx, s_fc, s_err} !== {2'b11, 6'd0, 8'd1, 1'b0}) begin
      n_bad++; $display("FAIL missing_restart: got stb=%0b fs=%0b slot=%0d fcnt=%0d err=%0b expected 1/1/0/1/0",
                        s_stb, s_fs, s_idx, s_fc, s_err);
    end
  endtask

  task automatic test_simultaneous();
    bus.req = 4'b0000;
    for (int s = 1; s <= 39; s++) pulse320(1'b0);
    pulse320(1'b1);
    n_cmp++;
    if ({s_stb, s_fs, s_mk, s_idle, s_idx, s_err} !== {4'b1110, 6'd0, 1'b0}) begin
      n_bad++; $display("FAIL simul_slot0: got stb=%0b fs=%0b mk=%0b idle=%0b slot=%0d err=%0b expected 1/1/1/0/0/0",
                        s_stb, s_fs, s_mk, s_idle, s_idx, s_err);
    end
    n_cmp++;
    if (s_fc !== 8'd2) begin n_bad++; $display("FAIL simul_fcnt: got %0d expected 2", s_fc); end
  endtask

  task automatic test_enable_reset();
    for (int s = 1; s <= 10; s++) pulse320(1'b0);
    pulse8k();
    enable = 1'b0;
    man320 = 1'b1;
    @(negedge clk80);
    n_cmp++;
    if ({bus.word_stb, bus.frame_start, bus.slot_idx} !== {2'b00, 6'd0}) begin
      n_bad++; $display("FAIL en_drop_suppress: got stb=%0b fs=%0b slot=%0d expected 0/0/0",
                        bus.word_stb, bus.frame_start, bus.slot_idx);
    end
    man320 = 1'b0;
    enable = 1'b1;
    @(negedge clk80);
    pulse320(1'b0);
    n_cmp++;
    if (s_stb !== 1'b0) begin n_bad++; $display("FAIL en_pend_cleared: got stb=%0b expected 0", s_stb); end
    pulse8k();
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_fs, s_idx, s_fc} !== {2'b11, 6'd0, 8'd2}) begin
      n_bad++; $display("FAIL en_restart: got stb=%0b fs=%0b slot=%0d fcnt=%0d expected 1/1/0/2",
                        s_stb, s_fs, s_idx, s_fc);
    end
    for (int s = 1; s <= 3; s++) pulse320(1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.slot_idx, frame_cnt, bus.word_stb} !== {6'd0, 8'd0, 1'b0}) begin
      n_bad++; $display("FAIL async_reset: got slot=%0d fcnt=%0d stb=%0b expected 0/0/0",
                        bus.slot_idx, frame_cnt, bus.word_stb);
    end
    @(negedge clk80);
    reset = 1'b1;
    @(negedge clk80);
    pulse320(1'b0);
    n_cmp++;
    if (s_stb !== 1'b0) begin n_bad++; $display("FAIL post_reset_no_stb: got %0b expected 0", s_stb); end
    pulse8k();
    pulse320(1'b0);
    n_cmp++;
    if ({s_stb, s_fs, s_idx} !== {2'b11, 6'd0}) begin
      n_bad++; $display("FAIL post_reset_frame: got stb=%0b fs=%0b slot=%0d expected 1/1/0", s_stb, s_fs, s_idx);
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_real_div();
    test_round_robin();
    test_single_req();
    test_resync();
    test_missing_frame();
    test_simultaneous();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
